ge_scalar_sched: RTL

- Parametrised scalar-walk sequencer for multi-scalar Ed25519 group-element multiplication (Shamir/Straus joint binary ladder).
- Scans NUM_S scalars from MSB to LSB in lockstep and emits a stream of point-op commands (DBL, ADD with base-point select) to the downstream point-op engine over a valid/ready handshake.
- Generalises the fixed two-scalar double-scalarmult controller to any scalar width and any scalar count.

---
 rtl/ge_pkg.sv | 29 ++
 rtl/ge_bit_column.sv | 26 ++
 rtl/ge_scalar_sched.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/ge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ge_pkg
// Purpose  : Shared opcodes, FSM state encoding and width helper.
// Revision : 1.0
// ============================================================================
package ge_pkg;

    localparam logic [1:0] GE_OP_NONE = 2'b00;
    localparam logic [1:0] GE_OP_DBL  = 2'b01;
    localparam logic [1:0] GE_OP_ADD  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SCAN = 3'd1,
        ST_DBL  = 3'd2,
        ST_ADD  = 3'd3,
        ST_FIN  = 3'd4
    } ge_state_e;

    function automatic int selw(input int n);
        if (n <= 1) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ge_bit_column.sv
`default_nettype none
// ============================================================================
// Module   : ge_bit_column
// Purpose  : Extracts bit idx of every scalar as one NUM_S-bit column.
// Revision : 1.0
// ============================================================================
module ge_bit_column
    import ge_pkg::*;
#(
    parameter int SCALAR_W = 256,
    parameter int NUM_S    = 2,
    localparam int IDX_W   = selw(SCALAR_W)
) (
    input  logic [NUM_S*SCALAR_W-1:0] scalars,
    input  logic [IDX_W-1:0]          idx,
    output logic [NUM_S-1:0]          column
);

    for (genvar g = 0; g < NUM_S; g++) begin : g_col
        logic [SCALAR_W-1:0] w_word;
        assign w_word    = scalars[g*SCALAR_W +: SCALAR_W];
        assign column[g] = w_word[idx];
    end

endmodule
`default_nettype wire

// File: rtl/ge_scalar_sched.sv
`default_nettype none
// ============================================================================
// Module   : ge_scalar_sched
// Purpose  : Joint MSB-first scalar walk emitting DBL/ADD point-op commands.
//            Optional abort support: define GE_SCHED_ABORT_EN.
// Revision : 1.0
// ============================================================================
module ge_scalar_sched
    import ge_pkg::*;
#(
    parameter int SCALAR_W = 256,
    parameter int NUM_S    = 2,
    localparam int SEL_W   = selw(NUM_S)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [NUM_S*SCALAR_W-1:0] scalars,
`ifdef GE_SCHED_ABORT_EN
    input  logic                      abort,
`endif
    output logic                      op_valid,
    input  logic                      op_ready,
    output logic [1:0]                op_code,
    output logic [SEL_W-1:0]          op_sel,
    output logic                      busy,
    output logic                      done,
`ifdef GE_SCHED_ABORT_EN
    output logic                      aborted,
`endif
    output logic                      zero_result
);

    localparam int IDX_W = selw(SCALAR_W);
    localparam logic [IDX_W-1:0] c_idx_top  = IDX_W'(SCALAR_W - 1);
    localparam logic [SEL_W-1:0] c_sel_last = SEL_W'(NUM_S - 1);

    ge_state_e                 state_q, state_d;
    logic [NUM_S*SCALAR_W-1:0] scal_q, scal_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [SEL_W-1:0]          sptr_q, sptr_d;
    logic                      zero_q, zero_d;
`ifdef GE_SCHED_ABORT_EN
    logic                      abrt_q, abrt_d;
`endif

    logic [NUM_S-1:0] w_column;
    logic             w_bit;
    logic             w_cmd;
    logic             w_abort;
    logic             w_fire;

    ge_bit_column #(
        .SCALAR_W (SCALAR_W),
        .NUM_S    (NUM_S)
    ) u_col (
        .scalars (scal_q),
        .idx     (idx_q),
        .column  (w_column)
    );

    assign w_bit = w_column[sptr_q];
    // A command is pending in DBL always, and in ADD only when the selected bit is set.
    assign w_cmd = (state_q == ST_DBL) || ((state_q == ST_ADD) && w_bit);
`ifdef GE_SCHED_ABORT_EN
    assign w_abort = abort && (state_q != ST_IDLE) && (state_q != ST_FIN);
`else
    assign w_abort = 1'b0;
`endif
    assign w_fire = w_cmd && !w_abort && op_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            scal_q  <= '0;
            idx_q   <= '0;
            sptr_q  <= '0;
            zero_q  <= 1'b0;
`ifdef GE_SCHED_ABORT_EN
            abrt_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            scal_q  <= scal_d;
            idx_q   <= idx_d;
            sptr_q  <= sptr_d;
            zero_q  <= zero_d;
`ifdef GE_SCHED_ABORT_EN
            abrt_q  <= abrt_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        scal_d  = scal_q;
        idx_d   = idx_q;
        sptr_d  = sptr_q;
        zero_d  = zero_q;
`ifdef GE_SCHED_ABORT_EN
        abrt_d  = abrt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    scal_d  = scalars;
                    idx_d   = c_idx_top;
                    sptr_d  = '0;
                    zero_d  = 1'b0;
`ifdef GE_SCHED_ABORT_EN
                    abrt_d  = 1'b0;
`endif
                    state_d = ST_SCAN;
                end
            end
            // Leading zero columns are skipped; the first nonzero column goes straight to ADD.
            ST_SCAN: begin
                if (|w_column) begin
                    sptr_d  = '0;
                    state_d = ST_ADD;
                end else if (idx_q == '0) begin
                    zero_d  = 1'b1;
                    state_d = ST_FIN;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            ST_DBL: begin
                if (w_fire) begin
                    sptr_d  = '0;
                    state_d = ST_ADD;
                end
            end
            ST_ADD: begin
                if (w_fire || !w_bit) begin
                    if (sptr_q == c_sel_last) begin
                        if (idx_q == '0) begin
                            state_d = ST_FIN;
                        end else begin
                            idx_d   = idx_q - IDX_W'(1);
                            state_d = ST_DBL;
                        end
                    end else begin
                        sptr_d = sptr_q + SEL_W'(1);
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
`ifdef GE_SCHED_ABORT_EN
        if (w_abort) begin
            abrt_d  = 1'b1;
            state_d = ST_FIN;
        end
`endif
    end

    always_comb begin
        op_valid    = w_cmd && !w_abort;
        op_code     = GE_OP_NONE;
        op_sel      = '0;
        if (op_valid) begin
            if (state_q == ST_DBL) begin
                op_code = GE_OP_DBL;
            end else begin
                op_code = GE_OP_ADD;
                op_sel  = sptr_q;
            end
        end
        busy        = (state_q == ST_SCAN) || (state_q == ST_DBL) || (state_q == ST_ADD);
        done        = (state_q == ST_FIN);
        zero_result = zero_q;
`ifdef GE_SCHED_ABORT_EN
        aborted     = abrt_q;
`endif
    end

endmodule
`default_nettype wire
